// File: rtl/wide_add_sched_pkg.sv
// Shared sizing and FSM encoding for the word-serial wide adder scheduler.
package wide_add_sched_pkg;

  localparam int W     = 32;
  localparam int WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cla_32bit.sv
// 32-bit two-level carry-lookahead adder: 4-bit groups, lookahead across groups.
module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        gp,
  output logic        gg
);

  logic [31:0] g;
  logic [31:0] p;

  assign g  = a & b;
  assign p  = a ^ b;
  assign gp = &p;

  always_comb begin : cla_net
    logic [7:0] grp_g;
    logic [7:0] grp_p;
    logic [8:0] grp_c;
    logic       c;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = 1'b0;
    sum   = '0;
    gg    = 1'b0;
    for (int j = 0; j < 8; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    grp_c[0] = cin;
    for (int j = 0; j < 8; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
      gg         = grp_g[j] | (grp_p[j] & gg);
    end
    // Bit carries inside a group only need that group's lookahead carry-in.
    for (int j = 0; j < 8; j++) begin
      c = grp_c[j];
      for (int i = 0; i < 4; i++) begin
        sum[4*j+i] = p[4*j+i] ^ c;
        c          = g[4*j+i] | (p[4*j+i] & c);
      end
    end
    cout = grp_c[8];
  end

endmodule

// File: rtl/wide_add_sched.sv
// Two-requester round-robin front end feeding a single CLA word-serially;
// one W-bit word per CALC cycle, result held in RESP until taken.
//   state | meaning
//   IDLE  | waiting for a request, round-robin grant drives ready
//   CALC  | adding word k of the latched operands, carry chained via register
//   RESP  | full sum presented, held until rsp_ready
module wide_add_sched #(
  parameter int W     = wide_add_sched_pkg::W,
  parameter int WORDS = wide_add_sched_pkg::WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [W*WORDS-1:0]   req0_a,
  input  logic [W*WORDS-1:0]   req0_b,
  input  logic [W*WORDS-1:0]   req1_a,
  input  logic [W*WORDS-1:0]   req1_b,
  input  logic                 req0_cin,
  input  logic                 req1_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [W*WORDS-1:0]   rsp_sum,
  output logic                 rsp_cout,
  output logic                 busy
);

  import wide_add_sched_pkg::*;

  localparam int N  = W * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic          last, grant, accept, word_last;
  logic          id_q, cin_q, carry_q;
  logic [N-1:0]  a_q, b_q, part_q;
  logic [W-1:0]  cla_sum;
  logic          cla_cin, cla_cout;
  logic          cla_gp_unused, cla_gg_unused;

  // On a tie the requester not granted last time wins.
  assign grant     = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign accept    = req0_ready || req1_ready;
  assign word_last = (k == KW'(WORDS - 1));
  assign cla_cin   = (k == '0) ? cin_q : carry_q;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  CLA_32bit u_cla (
    .a    (a_q[W-1:0]),
    .b    (b_q[W-1:0]),
    .cin  (cla_cin),
    .sum  (cla_sum),
    .cout (cla_cout),
    .gp   (cla_gp_unused),
    .gg   (cla_gg_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !grant;
        req1_ready = rst_n && req1_valid && grant;
        if (req0_ready || req1_ready) state_nxt = CALC;
      end
      CALC:    if (word_last) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right one word per CALC cycle; sum words enter from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      last     <= 1'b1;
      id_q     <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          a_q   <= req1_ready ? req1_a   : req0_a;
          b_q   <= req1_ready ? req1_b   : req0_b;
          cin_q <= req1_ready ? req1_cin : req0_cin;
          id_q  <= req1_ready;
          last  <= req1_ready;
          k     <= '0;
        end
        CALC: begin
          a_q     <= a_q >> W;
          b_q     <= b_q >> W;
          part_q  <= {cla_sum, part_q[N-1:W]};
          carry_q <= cla_cout;
          k       <= word_last ? '0 : k + 1'b1;
          if (word_last) begin
            rsp_sum  <= {cla_sum, part_q[N-1:W]};
            rsp_cout <= cla_cout;
            rsp_id   <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sched.sv
// Self-checking bench: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed expectations and a random soak.
module tb_wide_add_sched;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_ready = 1'b0;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [N-1:0] rsp_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wide_add_sched #(.W(W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_cin   (req0_cin),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction model: an accepted request owns the block for WORDS edges,
  // then the sum a+b+cin is offered until taken.
  logic         m_act, m_last, m_id, m_out_id;
  int           m_cnt;
  logic [N:0]   m_res, m_out;

  always @(negedge clk) begin
    logic e0, e1, ev;
    if (!rst_n) begin
      m_act = 1'b0; m_last = 1'b1; m_cnt = 0; m_id = 1'b0;
      m_res = '0; m_out = '0; m_out_id = 1'b0;
    end
    e0 = rst_n && !m_act && req0_valid && !(req1_valid && !m_last);
    e1 = rst_n && !m_act && req1_valid && !(req0_valid && m_last);
    ev = m_act && (m_cnt == WORDS);
    chk1("req0_ready", req0_ready, e0);
    chk1("req1_ready", req1_ready, e1);
    chk1("busy", busy, m_act);
    chk1("rsp_valid", rsp_valid, ev);
    chk("rsp_result", {rsp_cout, rsp_sum}, m_out);
    chk1("rsp_id", rsp_id, m_out_id);
    if (rst_n) begin
      if (m_act) begin
        if (m_cnt == WORDS) begin
          if (rsp_ready) m_act = 1'b0;
        end else begin
          m_cnt++;
          if (m_cnt == WORDS) begin
            m_out    = m_res;
            m_out_id = m_id;
          end
        end
      end else if (e0 || e1) begin
        m_id   = e1;
        m_last = e1;
        m_res  = e1 ? ({1'b0, req1_a} + {1'b0, req1_b} + (N+1)'(req1_cin))
                    : ({1'b0, req0_a} + {1'b0, req0_b} + (N+1)'(req0_cin));
        m_act  = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  logic       s_acc0, s_acc1, s_hs, s_rv, s_busy, s_rdy;
  logic       q_id[$];
  logic [N:0] q_res[$];

  task automatic tick();
    @(negedge clk);
    s_acc0 = req0_valid && req0_ready;
    s_acc1 = req1_valid && req1_ready;
    s_hs   = rsp_valid && rsp_ready;
    s_rv   = rsp_valid;
    s_busy = busy;
    s_rdy  = req0_ready || req1_ready;
    if (s_hs) begin
      q_id.push_back(rsp_id);
      q_res.push_back({rsp_cout, rsp_sum});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 60 && q_res.size() == 0; i++) begin
      tick();
      if (s_acc0) req0_valid = 1'b0;
      if (s_acc1) req1_valid = 1'b0;
    end
  endtask

  task automatic pop_check(input string name, input logic [N:0] exp_res, input logic exp_id);
    if (q_res.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no response seen, expected %0h", name, exp_res);
    end else begin
      chk(name, q_res.pop_front(), exp_res);
      chk1({name, "_id"}, q_id.pop_front(), exp_id);
    end
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    v = '0;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      default: for (int i = 0; i < WORDS; i++) v[i*W +: W] = $urandom;
    endcase
    return v;
  endfunction

  task automatic rand_drive();
    if (s_acc0 || !req0_valid) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_a = rand_op(); req0_b = rand_op(); req0_cin = 1'($urandom_range(0, 1));
    end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
    if (s_acc1 || !req1_valid) begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_a = rand_op(); req1_b = rand_op(); req1_cin = 1'($urandom_range(0, 1));
    end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
    rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, pulses, ops;
    logic stable;
    logic [N:0] snap;

    // Reset with a request already waiting: nothing may be ready during reset.
    req0_a = 128'd1; req0_b = 128'd2; req0_cin = 1'b1; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_result", {rsp_cout, rsp_sum}, '0);
    rst_n = 1'b1;

    // Single request, accepted on the first edge after release.
    tick();
    chk1("first_edge_accept", s_acc0, 1'b1);
    req0_valid = 1'b0;
    lat = 0;
    s_rv = 1'b0;
    for (int i = 0; i < 20 && !s_rv; i++) begin
      tick();
      if (!s_rv && s_busy) lat++;
    end
    chk_int("single_latency", lat, WORDS);
    pop_check("single_sum", 129'd4, 1'b0);

    // Full carry ripple across every word.
    req0_a = '1; req0_b = '0; req0_cin = 1'b1; req0_valid = 1'b1;
    wait_resp();
    pop_check("ripple_sum", {1'b1, 128'd0}, 1'b0);

    // Backpressure: last grant was req0, so req1 wins the tie.
    rsp_ready = 1'b0;
    req0_a = 128'd5; req0_b = 128'd7; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 128'd9; req1_b = 128'd10; req1_cin = 1'b1; req1_valid = 1'b1;
    s_rv = 1'b0;
    for (int i = 0; i < 40 && !s_rv; i++) begin
      tick();
      if (s_acc0) req0_valid = 1'b0;
      if (s_acc1) req1_valid = 1'b0;
    end
    chk1("bp_valid_seen", s_rv, 1'b1);
    snap = {rsp_cout, rsp_sum};
    chk("bp_held_sum", snap, 129'd20);
    pulses = 0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_rdy) pulses++;
      if (!s_rv || ({rsp_cout, rsp_sum} !== snap)) stable = 1'b0;
    end
    chk_int("bp_ready_pulses", pulses, 0);
    chk1("bp_stable", stable, 1'b1);
    rsp_ready = 1'b1;
    tick();
    chk1("bp_handshake", s_hs, 1'b1);
    tick();
    chk1("bp_resume_accept", s_acc0, 1'b1);
    req0_valid = 1'b0;
    pop_check("bp_sum", 129'd20, 1'b1);
    wait_resp();
    pop_check("bp_next_sum", 129'd12, 1'b0);

    // Tie fairness from reset: 0,1,0,1.
    rst_n = 1'b0;
    tick();
    req0_a = 128'd100; req0_b = 128'd1;  req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 128'd200; req1_b = 128'd3;  req1_cin = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 80 && q_res.size() < 4; i++) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pop_check("tie_0", 129'd101, 1'b0);
    pop_check("tie_1", 129'd204, 1'b1);
    pop_check("tie_2", 129'd101, 1'b0);
    pop_check("tie_3", 129'd204, 1'b1);

    // Reset while word 2 is in flight.
    req0_a = '1; req0_b = '1; req0_cin = 1'b1; req0_valid = 1'b1;
    s_acc0 = 1'b0;
    for (int i = 0; i < 20 && !s_acc0; i++) tick();
    req0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk1("midrst_rsp_valid", rsp_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk("midrst_result", {rsp_cout, rsp_sum}, '0);
    chk1("midrst_id", rsp_id, 1'b0);
    req0_a = 128'd3;  req0_b = 128'd4; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 128'd30; req1_b = 128'd4; req1_cin = 1'b0; req1_valid = 1'b1;
    rst_n = 1'b1;
    wait_resp();
    pop_check("midrst_next", 129'd7, 1'b0);
    wait_resp();
    pop_check("midrst_next2", 129'd34, 1'b1);

    // Random soak against the model.
    q_res.delete();
    q_id.delete();
    ops = 0;
    for (int c = 0; c < 30000 && ops < 1000; c++) begin
      tick();
      if (s_hs) ops++;
      rand_drive();
    end
    chk1("random_ops_done", ops >= 1000, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (WORDS + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_add_sched.md
WIDE_ADD_SCHED -- requirements
Module: wide_add_sched

Interface
REQ-001 The block SHALL have parameter W, default 32, the CLA word width in bits.
REQ-002 The block SHALL have parameter WORDS, default 4, the words per operand, so the operand width is W*WORDS (128 bits).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 holds an add request.
REQ-007 Ports req0_ready / req1_ready, output, 1 bit each: request accepted this cycle.
REQ-008 Ports req0_a, req0_b, req1_a, req1_b, input, W*WORDS bits each: operands.
REQ-009 Ports req0_cin / req1_cin, input, 1 bit each: carry-in.
REQ-010 Port rsp_valid, output, 1 bit: result available.
REQ-011 Port rsp_ready, input, 1 bit: consumer takes the result.
REQ-012 Port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-013 Port rsp_sum, output, W*WORDS bits: sum.
REQ-014 Port rsp_cout, output, 1 bit: carry-out of the most significant word.
REQ-015 Port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CALC and RESP.
REQ-017 In IDLE the block SHALL grant one request by round-robin:
- only one valid: grant it;
- both valid: grant the requester that was not last granted.
REQ-018 reqX_ready SHALL be combinational: IDLE, reqX_valid and grant==X; at most one ready is high per cycle; ready is never high outside IDLE.
REQ-019 On an accepting edge (valid&&ready) the block SHALL:
- latch a, b, cin and the requester id;
- update the last-granted pointer;
- go to CALC with word index k=0.
REQ-020 A valid that deasserts before acceptance SHALL have no effect; the pointer changes only on acceptance.
REQ-021 In CALC, cycle k SHALL present word k (bits W*k+W-1 : W*k) of a and b to the single shared CLA.
- Carry-in is the latched cin when k=0, otherwise the registered carry-out of word k-1.
REQ-022 Each CALC cycle SHALL register CLA sum word k and its carry-out; k increments; after word WORDS-1 the next state is RESP.
REQ-023 rsp_valid SHALL rise exactly WORDS clock edges after the accepting edge (4 with defaults).
REQ-024 In RESP, rsp_valid, rsp_sum, rsp_cout and rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-025 On the rsp_valid&&rsp_ready edge the block SHALL return to IDLE; no request is accepted on that same edge.
- Minimum spacing between accepts is WORDS+2 cycles.
REQ-026 rsp_sum/rsp_cout SHALL equal {a+b+cin} mod 2^(W*WORDS+1), including the full wrap-around case (all-ones + 1 gives sum 0, cout 1).
REQ-027 Outside RESP, rsp_valid SHALL be 0; rsp_sum/rsp_cout/rsp_id hold their last values.

Reset
REQ-028 While rst_n is low the block SHALL be in IDLE with:
- rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0;
- req0_ready=req1_ready=0;
- k=0;
- last-granted pointer=1, so req0 wins the first tie.
REQ-029 Reset asserted in CALC or RESP SHALL abort the operation immediately; the partial result is never presented.
REQ-030 After release, the first rising edge SHALL be able to accept a request.

Structure
REQ-031 A shared package SHALL hold W, WORDS and the state encoding IDLE/CALC/RESP.
REQ-032 The block SHALL instantiate exactly one existing CLA_32bit as its only adder sub-module.
- No behavioural '+' is used on operand data; '+' is allowed only on the index counter.
REQ-033 The CLA's gp/gg outputs SHALL be left unused.

Verification
REQ-034 Single request: req0 a=0x...0000_0001 (128b), b=0x...0000_0002, cin=1 -> rsp_valid 4 edges after accept, sum=4, cout=0, id=0.
REQ-035 Carry ripple: a=all-ones (128b), b=0, cin=1 -> sum=0, cout=1; word-to-word carry propagates across all 4 words.
REQ-036 Tie fairness: both valid continuously for 4 operations -> grant order 0,1,0,1; rsp_id matches each time.
REQ-037 Backpressure: rsp_ready held low 10 cycles -> rsp_valid and outputs stable, no ready pulses; accept resumes one cycle after handshake.
REQ-038 Reset mid-CALC: rst_n low at k=2 -> rsp_valid stays 0, all outputs reset; next request completes correctly with req0 winning the tie.
REQ-039 Randomized: 1000 random a, b, cin from both requesters -> every {rsp_cout, rsp_sum} equals the reference a+b+cin.
